// File: rtl/pe_inst_fetch_if.sv
// ============================================================================
// Module   : pe_inst_fetch_if
// Brief    : Load/start/controller handshake bundle for pe_inst_fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pe_inst_fetch_if #(
  parameter int instLen = 33,
  parameter int iterLen = 8
);
  logic               inst_wr;
  logic [instLen-1:0] inst_wr_data;
  logic               inst_clr;
  logic               start;
  logic [iterLen-1:0] num_iter;
  logic               inst_stall;
  logic               inst_eol;
  logic               inst_eoc;
  logic [instLen-1:0] inst_out;
  logic               inst_out_v;
  logic               eol_flag;
  logic               prog_full;
  logic               busy;
  logic               done;
  logic               overrun;
  logic [15:0]        stall_cnt;

  modport master (
    output inst_wr, inst_wr_data, inst_clr, start, num_iter,
           inst_stall, inst_eol, inst_eoc,
    input  inst_out, inst_out_v, eol_flag, prog_full, busy, done,
           overrun, stall_cnt
  );

  modport slave (
    input  inst_wr, inst_wr_data, inst_clr, start, num_iter,
           inst_stall, inst_eol, inst_eoc,
    output inst_out, inst_out_v, eol_flag, prog_full, busy, done,
           overrun, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pe_inst_fetch.sv
// ============================================================================
// Module   : pe_inst_fetch
// Brief    : Per-PE instruction buffer and loop sequencer feeding pe_controller.
//            Optional stall counter built when PE_FETCH_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_inst_fetch #(
  parameter int instLen     = 33,
  parameter int instAddrLen = 4,
  parameter int iterLen     = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  pe_inst_fetch_if.slave  bus
);

  localparam int                   DEPTH    = 2 ** instAddrLen;
  localparam logic [instAddrLen:0] FULL_PTR = (instAddrLen + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             state_q,   state_d;
  logic [instAddrLen-1:0] pc_q,      pc_d;
  logic [instAddrLen:0]   wr_ptr_q,  wr_ptr_d;
  logic [iterLen-1:0]     iter_q,    iter_d;
  logic [iterLen-1:0]     niter_q,   niter_d;
  logic                   overrun_q, overrun_d;
  logic [instLen-1:0]     mem_q [DEPTH];

  logic w_idle, w_run, w_full, w_start_acc, w_clr, w_wr_en;
  logic w_last_pass, w_last_word;

  assign w_idle      = (state_q == ST_IDLE);
  assign w_run       = (state_q == ST_RUN);
  assign w_full      = (wr_ptr_q == FULL_PTR);
  assign w_start_acc = w_idle & bus.start & (wr_ptr_q != '0);
  assign w_clr       = w_idle & bus.inst_clr & ~w_start_acc;
  assign w_wr_en     = w_idle & bus.inst_wr & ~bus.inst_clr & ~w_start_acc & ~w_full;
  assign w_last_pass = (iter_q == niter_q - iterLen'(1));
  assign w_last_word = ({1'b0, pc_q} == wr_ptr_q - (instAddrLen + 1)'(1));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wr_ptr_d  = wr_ptr_q;
    iter_d    = iter_q;
    niter_d   = niter_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (w_clr) begin
          wr_ptr_d = '0;
        end else if (w_wr_en) begin
          wr_ptr_d = wr_ptr_q + (instAddrLen + 1)'(1);
        end
        if (w_start_acc) begin
          pc_d      = '0;
          iter_d    = '0;
          niter_d   = (bus.num_iter == '0) ? iterLen'(1) : bus.num_iter;
          overrun_d = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // Stall freezes everything, including any eol/eoc seen this cycle.
        if (bus.inst_stall) begin
          pc_d = pc_q;
        end else if (bus.inst_eoc) begin
          state_d = ST_DONE;
        end else if (bus.inst_eol) begin
          pc_d   = '0;
          iter_d = iter_q + iterLen'(1);
          if (w_last_pass) begin
            state_d = ST_DONE;
          end
        end else if (w_last_word) begin
          overrun_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          pc_d = pc_q + instAddrLen'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      wr_ptr_q  <= '0;
      iter_q    <= '0;
      niter_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wr_ptr_q  <= wr_ptr_d;
      iter_q    <= iter_d;
      niter_q   <= niter_d;
      overrun_q <= overrun_d;
    end
  end

  // Program storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q[instAddrLen-1:0]] <= bus.inst_wr_data;
    end
  end

  assign bus.inst_out   = w_run ? mem_q[pc_q] : '0;
  assign bus.inst_out_v = w_run;
  assign bus.eol_flag   = w_run & w_last_pass;
  assign bus.prog_full  = w_full;
  assign bus.busy       = ~w_idle;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.overrun    = overrun_q;

`ifdef PE_FETCH_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_start_acc) begin
      stall_cnt_d = '0;
    end else if (w_run && bus.inst_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_inst_fetch.sv
// ============================================================================
// Module   : tb_pe_inst_fetch
// Brief    : Scoreboard bench for pe_inst_fetch (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_inst_fetch;

  localparam int IL = 33;
  localparam int AL = 4;
  localparam int NL = 8;

`ifdef PE_FETCH_PERF_EN
  localparam logic [15:0] EXP_STALL = 16'd4;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  localparam logic [IL-1:0] A = 33'h1_0000_00A1;
  localparam logic [IL-1:0] B = 33'h0_B00B_00B2;
  localparam logic [IL-1:0] C = 33'h1_CC00_00C3;
  localparam logic [IL-1:0] D = 33'h0_0D0D_0D04;
  localparam logic [IL-1:0] E = 33'h1_EEEE_0005;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pe_inst_fetch_if #(.instLen(IL), .iterLen(NL)) bus ();

  pe_inst_fetch #(.instLen(IL), .instAddrLen(AL), .iterLen(NL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            n_chk    = 0;
  int            n_fail   = 0;
  int            done_cnt = 0;
  int            exp_done = 0;
  logic [IL:0]   sb_q [$];
  logic [IL:0]   mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per valid instruction cycle.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.inst_out_v === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got inst_out %0h, expected no valid (t=%0t)",
                 bus.inst_out, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("inst_out", 64'(bus.inst_out), 64'(mon_e[IL-1:0]));
        chk("eol_flag", 64'(bus.eol_flag), 64'(mon_e[IL]));
      end
    end else if (reset === 1'b1) begin
      chk("inst_out_zero_when_invalid", 64'(bus.inst_out), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IL-1:0] w);
    bus.inst_wr      = 1'b1;
    bus.inst_wr_data = w;
    tick();
    bus.inst_wr      = 1'b0;
  endtask

  task automatic clr();
    bus.inst_clr = 1'b1;
    tick();
    bus.inst_clr = 1'b0;
  endtask

  task automatic start_run(input logic [NL-1:0] n);
    bus.start    = 1'b1;
    bus.num_iter = n;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic step(input logic [IL-1:0] inst, input logic ef,
                      input logic st, input logic eol, input logic eoc);
    sb_q.push_back({ef, inst});
    bus.inst_stall = st;
    bus.inst_eol   = eol;
    bus.inst_eoc   = eoc;
    tick();
    bus.inst_stall = 1'b0;
    bus.inst_eol   = 1'b0;
    bus.inst_eoc   = 1'b0;
  endtask

  task automatic expect_done();
    exp_done++;
    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("valid_in_done", 64'(bus.inst_out_v), 64'd0);
    tick();
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("busy_after_done", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bus.inst_wr = 1'b0; bus.inst_wr_data = '0; bus.inst_clr = 1'b0;
    bus.start = 1'b0; bus.num_iter = '0;
    bus.inst_stall = 1'b0; bus.inst_eol = 1'b0; bus.inst_eoc = 1'b0;

    #3;
    chk("rst_inst_out_v", 64'(bus.inst_out_v), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_prog_full", 64'(bus.prog_full), 64'd0);
    chk("rst_overrun", 64'(bus.overrun), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single pass A,B,C
    load(A); load(B); load(C);
    start_run(8'd1);
    chk("busy_in_run", 64'(bus.busy), 64'd1);
    step(A, 1'b1, 1'b0, 1'b0, 1'b0);
    step(B, 1'b1, 1'b0, 1'b0, 1'b0);
    step(C, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_done();

    // Three passes
    start_run(8'd3);
    for (int p = 0; p < 3; p++) begin
      step(A, p == 2, 1'b0, 1'b0, 1'b0);
      step(B, p == 2, 1'b0, 1'b0, 1'b0);
      step(C, p == 2, 1'b0, 1'b1, p == 2);
    end
    expect_done();

    // Stall 4 cycles on B with eoc asserted during stall (must be ignored)
    start_run(8'd1);
    step(A, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) step(B, 1'b1, 1'b1, 1'b0, 1'b1);
    step(B, 1'b1, 1'b0, 1'b0, 1'b0);
    step(C, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_done();
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(EXP_STALL));

    // num_iter=0 acts as 1; eol on final pass without eoc still finishes
    start_run(8'd0);
    step(A, 1'b1, 1'b0, 1'b0, 1'b0);
    step(B, 1'b1, 1'b0, 1'b0, 1'b0);
    step(C, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_done();
    chk("no_overrun_on_eol", 64'(bus.overrun), 64'd0);

    // Overrun on a 2-word program without eol
    clr();
    load(D); load(E);
    start_run(8'd1);
    step(D, 1'b1, 1'b0, 1'b0, 1'b0);
    step(E, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("overrun_set", 64'(bus.overrun), 64'd1);
    expect_done();
    chk("overrun_sticky", 64'(bus.overrun), 64'd1);
    start_run(8'd1);
    chk("overrun_cleared", 64'(bus.overrun), 64'd0);
    step(D, 1'b1, 1'b0, 1'b0, 1'b0);
    step(E, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_done();

    // Fill to capacity; 17th write must not land anywhere
    clr();
    for (int i = 0; i < 16; i++) load(33'h0_5A00_0000 | IL'(i));
    chk("prog_full_at_16", 64'(bus.prog_full), 64'd1);
    load(33'h1_FFFF_FFFF);
    chk("prog_full_after_17th", 64'(bus.prog_full), 64'd1);
    start_run(8'd1);
    for (int i = 0; i < 16; i++) step(33'h0_5A00_0000 | IL'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    expect_done();
    chk("overrun_full_prog", 64'(bus.overrun), 64'd1);
    clr();
    chk("prog_full_after_clr", 64'(bus.prog_full), 64'd0);
    bus.start = 1'b1; bus.num_iter = 8'd1;
    tick();
    bus.start = 1'b0;
    chk("empty_start_ignored", 64'(bus.busy), 64'd0);
    tick();
    chk("empty_start_still_idle", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-run at pc=1
    load(A); load(B); load(C);
    start_run(8'd1);
    step(A, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.inst_out_v), 64'd0);
    chk("async_rst_inst_out", 64'(bus.inst_out), 64'd0);
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_eol_flag", 64'(bus.eol_flag), 64'd0);
    chk("async_rst_done", 64'(bus.done), 64'd0);
    chk("async_rst_prog_full", 64'(bus.prog_full), 64'd0);
    tick(); tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    start_run(8'd1);
    chk("start_after_rst_ignored", 64'(bus.busy), 64'd0);
    tick();
    chk("no_done_after_rst", 64'(bus.done), 64'd0);

    tick(); tick();
    chk("done_pulse_count", 64'(done_cnt), 64'(exp_done));
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
